data_mem_access_unit: RTL

- Load/store access unit directly upstream of the 32x32 Harvard data RAM.
- Converts CPU byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-indexed RAM transactions.
- Performs read-modify-write for sub-word stores, and lane extraction with sign/zero extension for loads.
- Flags misaligned and out-of-range accesses without touching RAM.

---
 rtl/data_mem_access_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/data_mem_access_unit.sv
// Load/store access unit between the CPU and the word-indexed data RAM.
// Handles sub-word loads (with extension), read-modify-write sub-word stores and access errors.
module data_mem_access_unit #(
    parameter int unsigned RAM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata,
    output logic        ram_write_en,
    output logic        ram_read_en
);

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;
    logic        acc_err;

    assign acc_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || ({2'b00, req_addr[31:2]} >= 32'(RAM_WORDS));

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'h0, wd[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'h0, wd} << {lane[1], 4'b0000};
        end
        return (word & ~mask) | data;
    endfunction

    // All outputs are registered and updated on the transition into the state that owns them;
    // the async reset clears the RAM strobes immediately so an interrupted store never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_err      <= 1'b0;
            ram_read_en   <= 1'b0;
            ram_write_en  <= 1'b0;
            ram_address   <= 32'h0;
            ram_writedata <= 32'h0;
            lat_write     <= 1'b0;
            lat_size      <= 2'b00;
            lat_signed    <= 1'b0;
            lat_lane      <= 2'b00;
            lat_wdata     <= 16'h0;
        end else begin
            resp_valid   <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_lane   <= req_addr[1:0];
                        lat_wdata  <= req_wdata[15:0];
                        if (acc_err) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_write && req_size == 2'b10) begin
                            state         <= WR;
                            ram_write_en  <= 1'b1;
                            ram_address   <= {2'b00, req_addr[31:2]};
                            ram_writedata <= req_wdata;
                        end else begin
                            state       <= RD;
                            ram_read_en <= 1'b1;
                            ram_address <= {2'b00, req_addr[31:2]};
                        end
                    end
                end
                RD: begin
                    if (lat_write) begin
                        state         <= WR;
                        ram_write_en  <= 1'b1;
                        ram_writedata <= merge_store(ram_readdata, lat_size, lat_lane, lat_wdata);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= extract_load(ram_readdata, lat_size, lat_signed, lat_lane);
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
